// File: rtl/write_test_sequencer_if.sv
// Datapath side of the write-throughput sequencer:
// pipe strobe, FIFO/checker status and the datapath resets.
interface write_test_sequencer_if;
  logic        pipe_in_write;
  logic        fifo_empty;
  logic        fifo_valid;
  logic [31:0] error_count_in;
  logic        fifo_rst;
  logic        checker_rst;
  logic        pattern_rst;

  modport master (
    input  pipe_in_write,
    input  fifo_empty,
    input  fifo_valid,
    input  error_count_in,
    output fifo_rst,
    output checker_rst,
    output pattern_rst
  );

  modport slave (
    output pipe_in_write,
    output fifo_empty,
    output fifo_valid,
    output error_count_in,
    input  fifo_rst,
    input  checker_rst,
    input  pattern_rst
  );
endinterface

// File: rtl/write_test_sequencer.sv
// Sequences one host-to-FPGA write-throughput run:
// flush, arm, count, drain, then freeze results.
module write_test_sequencer #(
  parameter int unsigned RESET_HOLD_CYCLES = 8,
  parameter int unsigned RECOVER_CYCLES    = 4,
  parameter int unsigned TIMEOUT_CYCLES    = 16777216
) (
  input  logic        okClk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] transfer_words,
  write_test_sequencer_if.master dp,
  output logic [63:0] clk_counts,
  output logic [31:0] words_received,
  output logic [31:0] words_checked,
  output logic [31:0] error_count,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic        bad_length,
  output logic        overrun,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FLUSH   = 3'd1,
    RECOVER = 3'd2,
    ARMED   = 3'd3,
    RUN     = 3'd4,
    DRAIN   = 3'd5,
    DONE    = 3'd6,
    ERROR   = 3'd7
  } state_t;

  localparam logic [31:0] HOLD_LAST = 32'(RESET_HOLD_CYCLES - 1);
  localparam logic [31:0] REC_LAST  = 32'(RECOVER_CYCLES - 1);
  localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_CYCLES - 1);

  state_t      st;
  logic [31:0] xfer;
  logic [31:0] cnt;
  logic [31:0] inact;
  logic        flush_rst;

  logic        activity;
  logic        stalled;
  logic        drained;
  logic        len_bad;

  assign activity = dp.pipe_in_write | dp.fifo_valid;
  assign stalled  = !activity && (inact == TO_LAST);
  assign drained  = dp.fifo_empty
                 && (words_checked == {1'b0, xfer[31:1]});
  assign len_bad  = (transfer_words == 32'd0)
                 || transfer_words[0];

  assign state          = st;
  assign dp.fifo_rst    = flush_rst;
  assign dp.checker_rst = flush_rst;
  assign dp.pattern_rst = flush_rst;

  always_ff @(posedge okClk) begin
    if (reset) begin
      st             <= IDLE;
      xfer           <= '0;
      cnt            <= '0;
      inact          <= '0;
      flush_rst      <= 1'b0;
      clk_counts     <= '0;
      words_received <= '0;
      words_checked  <= '0;
      error_count    <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      timeout        <= 1'b0;
      bad_length     <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      unique case (st)
        IDLE, DONE, ERROR: begin
          if (start) begin
            xfer           <= transfer_words;
            cnt            <= '0;
            inact          <= '0;
            clk_counts     <= '0;
            words_received <= '0;
            words_checked  <= '0;
            error_count    <= '0;
            timeout        <= 1'b0;
            overrun        <= 1'b0;
            if (len_bad) begin
              st         <= ERROR;
              bad_length <= 1'b1;
              done       <= 1'b1;
              busy       <= 1'b0;
            end else begin
              st         <= FLUSH;
              bad_length <= 1'b0;
              done       <= 1'b0;
              busy       <= 1'b1;
              flush_rst  <= 1'b1;
            end
          end
        end
        FLUSH: begin
          if (cnt == HOLD_LAST) begin
            st        <= RECOVER;
            cnt       <= '0;
            flush_rst <= 1'b0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        RECOVER: begin
          if (cnt == REC_LAST) begin
            st    <= ARMED;
            inact <= '0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        ARMED: begin
          if (dp.pipe_in_write) begin
            st             <= RUN;
            words_received <= 32'd1;
            clk_counts     <= 64'd1;
            inact          <= '0;
          end else if (stalled) begin
            st          <= ERROR;
            timeout     <= 1'b1;
            done        <= 1'b1;
            busy        <= 1'b0;
            error_count <= dp.error_count_in;
          end else begin
            inact <= activity ? '0 : inact + 32'd1;
          end
        end
        RUN: begin
          if (stalled) begin
            st          <= ERROR;
            timeout     <= 1'b1;
            done        <= 1'b1;
            busy        <= 1'b0;
            error_count <= dp.error_count_in;
          end else begin
            clk_counts <= clk_counts + 64'd1;
            inact      <= activity ? '0 : inact + 32'd1;
            if (dp.fifo_valid)
              words_checked <= words_checked + 32'd1;
            if (dp.pipe_in_write && words_received != xfer) begin
              words_received <= words_received + 32'd1;
              if (words_received + 32'd1 == xfer)
                st <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // surplus writes are flagged but never counted
          if (dp.pipe_in_write)
            overrun <= 1'b1;
          if (drained) begin
            st          <= DONE;
            done        <= 1'b1;
            busy        <= 1'b0;
            error_count <= dp.error_count_in;
          end else if (stalled) begin
            st          <= ERROR;
            timeout     <= 1'b1;
            done        <= 1'b1;
            busy        <= 1'b0;
            error_count <= dp.error_count_in;
          end else begin
            clk_counts <= clk_counts + 64'd1;
            inact      <= activity ? '0 : inact + 32'd1;
            if (dp.fifo_valid)
              words_checked <= words_checked + 32'd1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule
